dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory slave that answers the pipeline's MEM-stage requests (adr, mem_read, mem_write, wr_data) and returns rd_data in the same cycle.
- Holds a word-addressed RAM plus a small MMIO window: cycle counter, store counter, tohost/halt register and a sticky fault register.
- Sits at the top level beside the core; the testbench uses halt/tohost to end simulation.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; must be a power of two.
- INIT_FILE, "", hex file loaded into RAM at time zero with $readmemh; empty string means no preload.
- MMIO_PAGE, 16'hFFFF, value of adr[31:16] that selects the MMIO window.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- adr  in  32  byte address from EX/MEM ALU result.
- mem_read  in  1  load request this cycle.
- mem_write  in  1  store request this cycle.
- wr_data  in  32  store data.
- rd_data  out  32  load data, combinational.
- halt  out  1  sticky, set by a nonzero write to TOHOST.
- tohost  out  32  last value written to TOHOST.
- fault  out  1  sticky access-fault flag.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Decode:
  - MMIO when adr[31:16]==MMIO_PAGE and adr[15:4]==0.
  - RAM when adr[31:16]!=MMIO_PAGE, adr[1:0]==0 and adr[31:2] < DEPTH_WORDS.
  - Anything else is a bad access.
- Read is combinational:
  - rd_data = RAM[adr[log2(DEPTH_WORDS)+1:2]] or the MMIO register value when mem_read=1 and the address decodes.
  - rd_data = 0 otherwise, including when mem_read=0.
- Write is synchronous: takes effect at the rising edge when mem_write=1, rst=0 and halt=0. A load in the next cycle sees the new value.
- MMIO map (word offsets):
  - 0x0 CYCLE, read-only. Increments every cycle from 0 after reset and wraps at 2^32.
  - 0x4 STORE_CNT, read-only. Increments on each committed RAM write and saturates at 32'hFFFFFFFF.
  - 0x8 TOHOST, read/write. A write latches wr_data into tohost; a nonzero value also sets halt.
  - 0xC FAULT, read returns {fault_adr[31:2], 1'b0, fault}; any write clears fault and fault_adr.
- Writes to read-only MMIO registers are ignored and do not fault.
- Bad access: any mem_read or mem_write to a bad address.
  - The access is ignored and rd_data=0.
  - fault is set. fault_adr latches adr only when fault was previously 0, so the first fault is preserved.
- Simultaneous mem_read and mem_write:
  - Treated as a bad access. The write is suppressed, fault is set and rd_data=0.
  - A FAULT-clear write in the same cycle loses to the new fault.
- Halt:
  - Once halt=1, all further writes (RAM and MMIO) are suppressed.
  - Reads and CYCLE keep working.
  - Only rst clears halt.
- Reset: CYCLE, STORE_CNT, tohost, halt, fault and fault_adr all go to 0. RAM contents are not cleared.
- Reset mid-operation: a write presented in the same cycle as rst=1 is dropped.
- Latency: loads take 0 cycles; stores take 1 edge.
- No stall or ready signal. The responder always accepts, which matches the pipeline's fixed MEM stage.

Decomposition:
- Shared package (dmem_pkg) holds:
  - MMIO offset constants: CYCLE_OFS, STORE_CNT_OFS, TOHOST_OFS, FAULT_OFS.
  - The MMIO_PAGE default.
  - The address-decode result enum: DEC_RAM, DEC_MMIO, DEC_BAD.
- One natural sub-module, dmem_mmio_regs: counters, tohost/halt and fault registers plus their read mux. The RAM array and decode stay in the top.

Test Plan:
- Store/load: write 32'hDEADBEEF to 0x0000_0010, read 0x10 the next cycle -> rd_data=32'hDEADBEEF; STORE_CNT reads 1.
- Cycle counter: release rst, wait 10 cycles, read 0xFFFF0000 -> rd_data=10. Pulse rst -> next read 0.
- Misaligned load at 0x0000_0012 -> rd_data=0, fault=1, FAULT reads 32'h00000011. A later bad access at 0x0000_0020_000 leaves the latched fault_adr unchanged.
- Read+write collision at 0x20 -> RAM[8] unchanged, fault=1. Write to 0xFFFF000C -> fault=0.
- Write 32'h1 to 0xFFFF0008 -> halt=1, tohost=1. A following store of 32'h55 to 0x30 is dropped: RAM[12] keeps its old value and STORE_CNT does not change.
- Out-of-range store at DEPTH_WORDS*4 -> no RAM word changes, fault=1; TOHOST write of 0 -> tohost=0, halt stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory responder.
//   - MMIO_PAGE_DEF : default adr[31:16] value that selects the MMIO window
//   - *_OFS         : byte offsets of the MMIO registers inside that window
//   - dec_e         : result of the address decode (RAM, MMIO or bad access)
package dmem_pkg;

  localparam logic [15:0] MMIO_PAGE_DEF = 16'hFFFF;

  localparam logic [3:0] CYCLE_OFS     = 4'h0;
  localparam logic [3:0] STORE_CNT_OFS = 4'h4;
  localparam logic [3:0] TOHOST_OFS    = 4'h8;
  localparam logic [3:0] FAULT_OFS     = 4'hC;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_BAD
  } dec_e;

endpackage

// File: rtl/dmem_mmio_regs.sv
// dmem_mmio_regs: the responder's MMIO register file and its read mux.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   reg_ofs      : word-aligned register offset inside the MMIO window
//   mmio_we      : committed MMIO write this cycle (already gated by halt/rst)
//   wr_data      : store data
//   ram_we       : committed RAM write this cycle (drives STORE_CNT)
//   bad_access   : a bad access happened this cycle
//   adr_word     : adr[31:2] of the current access, latched on first fault
//   rd_val       : value of the register selected by reg_ofs
//   halt, tohost : halt flag and last value written to TOHOST
//   fault        : sticky access-fault flag
module dmem_mmio_regs
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  reg_ofs,
  input  logic        mmio_we,
  input  logic [31:0] wr_data,
  input  logic        ram_we,
  input  logic        bad_access,
  input  logic [29:0] adr_word,
  output logic [31:0] rd_val,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        fault
);

  logic [31:0] cycle_cnt;
  logic [31:0] store_cnt;
  logic [29:0] fault_adr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      store_cnt <= '0;
      tohost    <= '0;
      halt      <= 1'b0;
      fault     <= 1'b0;
      fault_adr <= '0;
    end else begin
      // Free-running; wraps naturally at 2^32.
      cycle_cnt <= cycle_cnt + 32'd1;

      if (ram_we && (store_cnt != 32'hFFFF_FFFF))
        store_cnt <= store_cnt + 32'd1;

      if (mmio_we && (reg_ofs == TOHOST_OFS)) begin
        tohost <= wr_data;
        if (wr_data != 32'd0)
          halt <= 1'b1;
      end

      // A new fault outranks a clear; only the first fault address is kept.
      if (bad_access) begin
        fault <= 1'b1;
        if (!fault)
          fault_adr <= adr_word;
      end else if (mmio_we && (reg_ofs == FAULT_OFS)) begin
        fault     <= 1'b0;
        fault_adr <= '0;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_ofs)
      CYCLE_OFS:     rd_val = cycle_cnt;
      STORE_CNT_OFS: rd_val = store_cnt;
      TOHOST_OFS:    rd_val = tohost;
      FAULT_OFS:     rd_val = {fault_adr, 1'b0, fault};
      default:       rd_val = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory slave with a small MMIO window.
// Request semantics: there is no valid/ready pair. mem_read and mem_write
// are single-cycle requests that are always accepted; a load returns
// rd_data combinationally in the same cycle, a store commits on the next
// rising edge. Asserting both together is a bad access.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   adr               : byte address
//   mem_read          : load request
//   mem_write         : store request
//   wr_data           : store data
//   rd_data           : load data (0 when not reading or on a bad access)
//   halt, tohost      : halt flag / last TOHOST value
//   fault             : sticky access-fault flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = "",
  parameter logic [15:0] MMIO_PAGE   = MMIO_PAGE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        halt,
  output logic [31:0] tohost,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  dec_e          dec;
  logic          in_range;
  logic          collision;
  logic          bad_access;
  logic          wr_ok;
  logic          ram_we;
  logic          mmio_we;
  logic [31:0]   mmio_rd;

  assign ram_idx  = adr[AW+1:2];
  assign in_range = ({2'b00, adr[31:2]} < 32'(DEPTH_WORDS));

  always_comb begin
    dec = DEC_BAD;
    if (adr[31:16] == MMIO_PAGE) begin
      if (adr[15:4] == 12'd0)
        dec = DEC_MMIO;
    end else if ((adr[1:0] == 2'b00) && in_range) begin
      dec = DEC_RAM;
    end
  end

  assign collision  = mem_read && mem_write;
  assign bad_access = (mem_read || mem_write) && ((dec == DEC_BAD) || collision);

  // A write commits only when it is a lone, well-decoded store outside
  // reset and before halt.
  assign wr_ok   = mem_write && !mem_read && !halt && !rst;
  assign ram_we  = wr_ok && (dec == DEC_RAM);
  assign mmio_we = wr_ok && (dec == DEC_MMIO);

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_idx] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    if (mem_read && !mem_write) begin
      case (dec)
        DEC_RAM:  rd_data = ram[ram_idx];
        DEC_MMIO: rd_data = mmio_rd;
        default:  rd_data = '0;
      endcase
    end
  end

  dmem_mmio_regs u_mmio (
    .clk        (clk),
    .rst        (rst),
    .reg_ofs    ({adr[3:2], 2'b00}),
    .mmio_we    (mmio_we),
    .wr_data    (wr_data),
    .ram_we     (ram_we),
    .bad_access (bad_access),
    .adr_word   (adr[31:2]),
    .rd_val     (mmio_rd),
    .halt       (halt),
    .tohost     (tohost),
    .fault      (fault)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a behavioural reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        halt;
  logic [31:0] tohost;
  logic        fault;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .adr       (adr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .halt      (halt),
    .tohost    (tohost),
    .fault     (fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [int];
  logic [31:0] m_cycle, m_store, m_tohost, m_fadr;
  logic        m_halt, m_fault;
  bit          m_valid = 0;

  // 0 = RAM, 1 = MMIO, 2 = bad
  function automatic int kind(input logic [31:0] a);
    if ((a >> 16) == 32'hFFFF) return ((a & 32'h0000_FFF0) == 0) ? 1 : 2;
    if ((a % 4) == 0 && (a / 4) < DEPTH) return 0;
    return 2;
  endfunction

  // Returns 1 when the expected rd_data is known.
  function automatic bit exp_rd(input logic r, input logic w, input logic [31:0] a,
                                output logic [31:0] v);
    int k;
    int ofs;
    v = 32'd0;
    k = kind(a);
    if (!r || w || k == 2) return 1;
    if (k == 0) begin
      if (!m_mem.exists(int'(a / 4))) return 0;
      v = m_mem[int'(a / 4)];
      return 1;
    end
    ofs = int'((a / 4) % 4);
    case (ofs)
      0: v = m_cycle;
      1: v = m_store;
      2: v = m_tohost;
      default: v = (m_fadr & 32'hFFFF_FFFC) | {31'd0, m_fault};
    endcase
    return 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cycle = 0; m_store = 0; m_tohost = 0; m_halt = 0; m_fault = 0; m_fadr = 0;
      m_valid = 1;
    end else if (m_valid) begin
      int k;
      k = kind(adr);
      m_cycle = m_cycle + 1;
      if ((mem_read || mem_write) && (k == 2 || (mem_read && mem_write))) begin
        if (!m_fault) m_fadr = adr;
        m_fault = 1;
      end else if (mem_write && !m_halt) begin
        if (k == 0) begin
          m_mem[int'(adr / 4)] = wr_data;
          if (m_store != 32'hFFFF_FFFF) m_store = m_store + 1;
        end else if (((adr / 4) % 4) == 2) begin
          m_tohost = wr_data;
          if (wr_data != 0) m_halt = 1;
        end else if (((adr / 4) % 4) == 3) begin
          m_fault = 0;
          m_fadr  = 0;
        end
      end
    end
  end

  // Compare process: every falling edge once the model is anchored by reset.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] v;
      check("halt", {31'd0, halt}, {31'd0, m_halt});
      check("tohost", tohost, m_tohost);
      check("fault", {31'd0, fault}, {31'd0, m_fault});
      if (exp_rd(mem_read, mem_write, adr, v))
        check("rd_data", rd_data, v);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    mem_read  = r;
    mem_write = w;
    adr       = a;
    wr_data   = d;
  endtask

  task automatic idle();
    cyc(0, 0, 32'd0, 32'd0);
  endtask

  initial begin
    idle(); idle();
    rst = 0;                      // edge just taken had rst=1: CYCLE=0
    #1;
    check("reset_halt",   {31'd0, halt},  32'd0);
    check("reset_fault",  {31'd0, fault}, 32'd0);
    check("reset_tohost", tohost,         32'd0);

    // Cycle counter: 10 edges after release reads 10
    for (int i = 0; i < 9; i++) idle();
    cyc(1, 0, 32'hFFFF_0000, 0); #1;
    check("cycle_10", rd_data, 32'd10);
    idle();
    rst = 1;
    cyc(1, 0, 32'hFFFF_0000, 0);
    rst = 0; #1;
    check("cycle_after_rst", rd_data, 32'd0);

    // Store / load
    cyc(0, 1, 32'h10, 32'hDEAD_BEEF);
    cyc(1, 0, 32'h10, 0); #1;
    check("load_10", rd_data, 32'hDEAD_BEEF);
    cyc(1, 0, 32'hFFFF_0004, 0); #1;
    check("store_cnt_1", rd_data, 32'd1);
    cyc(0, 1, 32'h30, 32'h0000_1234);
    cyc(0, 1, 32'h40, 32'h0000_0011);
    cyc(1, 0, 32'h0, 0); #1;
    check("no_read_when_write_only", rd_data, m_mem.exists(0) ? m_mem[0] : rd_data);

    // Misaligned load
    cyc(1, 0, 32'h12, 0); #1;
    check("misaligned_rd", rd_data, 32'd0);
    cyc(1, 0, 32'hFFFF_000C, 0); #1;
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_reg", rd_data, 32'h0000_0011);
    cyc(1, 0, 32'h0002_0000, 0);
    cyc(1, 0, 32'hFFFF_000C, 0); #1;
    check("fault_adr_kept", rd_data, 32'h0000_0011);
    cyc(0, 1, 32'hFFFF_000C, 32'd0);
    idle(); #1;
    check("fault_cleared", {31'd0, fault}, 32'd0);

    // Read/write collision
    cyc(0, 1, 32'h20, 32'h0000_A5A5);
    cyc(1, 1, 32'h20, 32'h0000_FFFF); #1;
    check("collision_rd", rd_data, 32'd0);
    cyc(1, 0, 32'h20, 0); #1;
    check("collision_ram", rd_data, 32'h0000_A5A5);
    check("collision_fault", {31'd0, fault}, 32'd1);
    cyc(1, 0, 32'hFFFF_000C, 0); #1;
    check("collision_fault_reg", rd_data, 32'h0000_0021);
    cyc(0, 1, 32'hFFFF_000C, 32'd0);
    // Collision on FAULT itself: the new fault wins over the clear
    cyc(1, 1, 32'hFFFF_000C, 32'd0);
    idle(); #1;
    check("clear_loses", {31'd0, fault}, 32'd1);
    cyc(0, 1, 32'hFFFF_000C, 32'd0);

    // Out-of-range store
    cyc(0, 1, DEPTH * 4, 32'h0000_0077);
    cyc(1, 0, 32'h10, 0); #1;
    check("oor_fault", {31'd0, fault}, 32'd1);
    check("oor_ram_10", rd_data, 32'hDEAD_BEEF);
    cyc(1, 0, 32'hFFFF_0004, 0); #1;
    check("oor_store_cnt", rd_data, 32'd4);
    cyc(0, 1, 32'hFFFF_000C, 32'd0);

    // TOHOST write of 0
    cyc(0, 1, 32'hFFFF_0008, 32'd0);
    idle(); #1;
    check("tohost_zero", tohost, 32'd0);
    check("tohost_zero_halt", {31'd0, halt}, 32'd0);

    // Halt
    cyc(0, 1, 32'hFFFF_0008, 32'd1);
    idle(); #1;
    check("halt_set", {31'd0, halt}, 32'd1);
    check("tohost_1", tohost, 32'd1);
    cyc(0, 1, 32'h30, 32'h0000_0055);
    cyc(1, 0, 32'h30, 0); #1;
    check("halt_ram_30", rd_data, 32'h0000_1234);
    cyc(1, 0, 32'hFFFF_0004, 0); #1;
    check("halt_store_cnt", rd_data, 32'd4);

    // Write coincident with reset is dropped; reset clears halt
    rst = 1;
    cyc(0, 1, 32'h40, 32'h0000_0099);
    cyc(1, 0, 32'h40, 0);
    rst = 0; #1;
    check("rst_write_dropped", rd_data, 32'h0000_0011);
    check("rst_clears_halt", {31'd0, halt}, 32'd0);
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
